io_hold_bank: RTL



---
 rtl/io_hold_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/io_hold_bank.sv
// io_hold_bank: multi-channel IO input hold bank.
//   Each channel's raw IO is synchronised (2 flops), debounced, and tracked
//   for changes. A bus write to a channel's address captures its debounced
//   value into a hold register; a bus read returns a hold register one cycle
//   later.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   io_in      raw IO, channel i at [i*WIDTH +: WIDTH]
//   address    bus address (channel i at BASE_ADDR+i)
//   writemem   capture strobe
//   readmem    read strobe
//   data_out   registered read data (0 when no valid read)
//   hold_out   all hold registers, packed like io_in
//   changed    per-channel sticky "debounced value changed since capture"
//   addr_err   one-cycle pulse on an access outside the channel range

// Per-channel lane: synchroniser, debouncer, hold register, change flag.
module io_hold_lane #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_in,
    input  logic             capture,
    output logic [WIDTH-1:0] hold,
    output logic             changed
);
    localparam int CW = $clog2(DEBOUNCE) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] sync1, sync2, cand, stable;
    logic [CW-1:0]    cnt;
    logic             settle, upd;

    // cnt saturates at CNT_MAX, so equality is the "done" test
    assign settle = (sync2 == cand) && (cnt == CNT_MAX);
    assign upd    = settle && (cand != stable);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            cand    <= '0;
            cnt     <= '0;
            stable  <= '0;
            hold    <= '0;
            changed <= 1'b0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end else begin
                stable <= cand;
            end
            // capture takes the pre-edge stable value
            if (capture)
                hold <= stable;
            // a new stable value beats a same-edge capture clear
            if (upd)
                changed <= 1'b1;
            else if (capture)
                changed <= 1'b0;
        end
    end
endmodule

module io_hold_bank #(
    parameter int                WIDTH     = 8,
    parameter int                CHANNELS  = 4,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEBOUNCE  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] io_in,
    input  logic [ADDR_W-1:0]         address,
    input  logic                      writemem,
    input  logic                      readmem,
    output logic [WIDTH-1:0]          data_out,
    output logic [CHANNELS*WIDTH-1:0] hold_out,
    output logic [CHANNELS-1:0]       changed,
    output logic                      addr_err
);
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic              rd;
    } bus_req_t;

    bus_req_t                          req;
    logic [ADDR_W:0]                   diff;
    logic [ADDR_W-1:0]                 idx;
    logic                              in_range;
    logic [CHANNELS-1:0][WIDTH-1:0]    hold_arr;
    logic [WIDTH-1:0]                  rd_data;

    assign req = '{addr: address, wr: writemem, rd: readmem};

    // Extra top bit acts as the borrow: set when address < BASE_ADDR.
    assign diff     = {1'b0, req.addr} - {1'b0, BASE_ADDR};
    assign idx      = diff[ADDR_W-1:0];
    assign in_range = !diff[ADDR_W] && (idx < ADDR_W'(CHANNELS));

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        io_hold_lane #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .io_in   (io_in[i*WIDTH +: WIDTH]),
            .capture (req.wr && in_range && (idx == ADDR_W'(i))),
            .hold    (hold_arr[i]),
            .changed (changed[i])
        );
    end

    assign hold_out = hold_arr;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (idx == ADDR_W'(i))
                rd_data = hold_arr[i];
    end

    // hold_arr is the pre-edge value, so read-during-capture returns old data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            addr_err <= 1'b0;
        end else begin
            data_out <= (req.rd && in_range) ? rd_data : '0;
            addr_err <= (req.rd || req.wr) && !in_range;
        end
    end
endmodule
